sblock_xbar: RTL and testbench

- Parametrised successor to the fixed 3-track switch block in the routing fabric tile.
- Each right/down output track is driven by a configurable crossbar selection instead of tri-state dots. The source can be any left or up input track, or "off".
- Configuration is loaded through a bit-serial valid/ready shift port into a shadow register, then committed atomically to the active register. Tiles can chain their config through cfg_so.

---
 rtl/fabric_pkg.sv | 19 +
 rtl/sblock_cfg_loader.sv | 101 ++++++++++
 rtl/sblock_xbar.sv | 89 ++++++++
 tb/tb_sblock_xbar.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fabric_pkg.sv
// Shared routing-fabric definitions: select-field sizing, the "off" code and
// the configuration loader state encoding.
package fabric_pkg;

  // Width of one crossbar select field for W tracks per side:
  // codes 0 (off), 1..W (left), W+1..2W (up).
  function automatic int sel_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

  localparam int SEL_OFF = 0;

  typedef enum logic [1:0] {
    CFG_IDLE  = 2'd0,
    CFG_LOAD  = 2'd1,
    CFG_ARMED = 2'd2
  } cfg_state_e;

endpackage

// File: rtl/sblock_cfg_loader.sv
// Bit-serial configuration loader: shadow shift register filled over a
// valid/ready port, then copied atomically into the active register.
//
// Handshake: a bit transfers on a rising clk edge where cfg_valid and
// cfg_ready are both high. cfg_ready is high only in LOAD and is dropped
// in a cycle where cfg_start is asserted, so a restart never also consumes
// a data bit. cfg_so carries shadow[0] during each transferring cycle and
// is 0 otherwise, so a downstream tile qualifies its valid with our ready.
module sblock_cfg_loader import fabric_pkg::*; #(
  parameter int NBITS = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_valid,
  input  logic             cfg_bit,
  input  logic             cfg_commit,
  output logic             cfg_ready,
  output logic             cfg_so,
  output logic             cfg_done,
  output logic [NBITS-1:0] active_o,
  output logic [1:0]       state_o
);

  localparam int CNTW = $clog2(NBITS + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NBITS - 1);

  cfg_state_e       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [NBITS-1:0] shadow_q, shadow_d;
  logic [NBITS-1:0] active_q, active_d;
  logic             done_q, done_d;
  logic             accept;
  logic             commit_go;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= CFG_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: cfg_start restarts from any state and beats a commit
  always_comb begin
    state_d = state_q;
    case (state_q)
      CFG_IDLE:  if (cfg_start) state_d = CFG_LOAD;
      CFG_LOAD: begin
        if (cfg_start)                   state_d = CFG_LOAD;
        else if (accept && cnt_q == LAST) state_d = CFG_ARMED;
      end
      CFG_ARMED: begin
        if (cfg_start)       state_d = CFG_LOAD;
        else if (cfg_commit) state_d = CFG_IDLE;
      end
      default: state_d = CFG_IDLE;
    endcase
  end

  // Output logic: handshake, serial out and commit qualification
  always_comb begin
    cfg_ready = (state_q == CFG_LOAD) && !cfg_start;
    accept    = cfg_ready && cfg_valid;
    commit_go = (state_q == CFG_ARMED) && cfg_commit && !cfg_start;
    cfg_so    = accept ? shadow_q[0] : 1'b0;
  end

  // Datapath next values: bit counter, shadow shift, active copy, done pulse
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = commit_go;
    if (cfg_start) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d    = cnt_q + CNTW'(1);
      shadow_d = {cfg_bit, shadow_q[NBITS-1:1]};
    end
    if (commit_go) active_d = shadow_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign cfg_done = done_q;
  assign active_o = active_q;
  assign state_o  = state_q;

endmodule

// File: rtl/sblock_xbar.sv
// Configurable switch block: every right/down track is a mux over
// {off, left tracks, up tracks} selected by a field of the active config.
module sblock_xbar import fabric_pkg::*; #(
  parameter int W       = 3,
  parameter int OUT_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] left_i,
  input  logic [W-1:0] up_i,
  output logic [W-1:0] right_o,
  output logic [W-1:0] down_o,
  input  logic         cfg_start,
  input  logic         cfg_valid,
  input  logic         cfg_bit,
  output logic         cfg_ready,
  output logic         cfg_so,
  input  logic         cfg_commit,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic [1:0]   cfg_state_o
);

  localparam int SELW  = sel_width(W);
  localparam int NBITS = 2 * W * SELW;
  localparam int NSRC  = 2 * W + 1;

  logic [NBITS-1:0] active;
  logic [NSRC-1:0]  src;
  logic [SELW-1:0]  sel [2*W];
  logic [2*W-1:0]   route;
  logic [W-1:0]     right_d, down_d;
  logic             err;

  sblock_cfg_loader #(.NBITS(NBITS)) u_loader (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_commit (cfg_commit),
    .cfg_ready  (cfg_ready),
    .cfg_so     (cfg_so),
    .cfg_done   (cfg_done),
    .active_o   (active),
    .state_o    (cfg_state_o)
  );

  // Source vector indexed directly by select code; code 0 is the constant off
  assign src = {up_i, left_i, 1'b0};

  for (genvar g = 0; g < 2 * W; g++) begin : g_sel
    assign sel[g] = active[g*SELW +: SELW];
  end

  // Crossbar muxes and out-of-range code detection
  always_comb begin
    route = '0;
    err   = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      if (int'(sel[i]) >= NSRC)         err      = 1'b1;
      else if (int'(sel[i]) != SEL_OFF) route[i] = src[sel[i]];
    end
    right_d = route[W-1:0];
    down_d  = route[2*W-1:W];
  end

  assign cfg_err = err;

  if (OUT_REG != 0) begin : g_reg
    logic [W-1:0] right_q, down_q;
    // Registered outputs: one cycle from input tracks to output tracks
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        right_q <= '0;
        down_q  <= '0;
      end else begin
        right_q <= right_d;
        down_q  <= down_d;
      end
    end
    assign right_o = right_q;
    assign down_o  = down_q;
  end else begin : g_comb
    assign right_o = right_d;
    assign down_o  = down_d;
  end

endmodule

// File: tb/tb_sblock_xbar.sv
// Bench for sblock_xbar: W=3 combinational instance plus two chained W=4
// registered instances sharing one serial config stream.
module tb_sblock_xbar;
  import fabric_pkg::*;

  logic clk = 1'b0;
  logic rst;

  // W=3, OUT_REG=0
  logic [2:0]  left3, up3, right3, down3;
  logic        start3, valid3, bit3, ready3, so3, commit3, done3, err3;
  logic [1:0]  state3;

  // W=4, OUT_REG=1, tile A feeds tile B through cfg_so
  logic [3:0]  left4, up4, ra, da, rb, db;
  logic        start4, valid4, bit4, commit4;
  logic        ready_a, so_a, done_a, err_a;
  logic        ready_b, so_b, done_b, err_b;
  logic        valid_b;
  logic [1:0]  state_a, state_b;

  assign valid_b = valid4 & ready_a;

  // Scoreboard
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [17:0] sh3;   // model of the W=3 shadow register
  logic [17:0] cur3;  // model of the W=3 active register
  logic [31:0] cfg_a, cfg_b;

  always #5 clk = ~clk;

  sblock_xbar #(.W(3), .OUT_REG(0)) dut (
    .clk(clk), .rst(rst), .left_i(left3), .up_i(up3),
    .right_o(right3), .down_o(down3),
    .cfg_start(start3), .cfg_valid(valid3), .cfg_bit(bit3),
    .cfg_ready(ready3), .cfg_so(so3), .cfg_commit(commit3),
    .cfg_done(done3), .cfg_err(err3), .cfg_state_o(state3)
  );

  sblock_xbar #(.W(4), .OUT_REG(1)) u_a (
    .clk(clk), .rst(rst), .left_i(left4), .up_i(up4),
    .right_o(ra), .down_o(da),
    .cfg_start(start4), .cfg_valid(valid4), .cfg_bit(bit4),
    .cfg_ready(ready_a), .cfg_so(so_a), .cfg_commit(commit4),
    .cfg_done(done_a), .cfg_err(err_a), .cfg_state_o(state_a)
  );

  sblock_xbar #(.W(4), .OUT_REG(1)) u_b (
    .clk(clk), .rst(rst), .left_i(left4), .up_i(up4),
    .right_o(rb), .down_o(db),
    .cfg_start(start4), .cfg_valid(valid_b), .cfg_bit(so_a),
    .cfg_ready(ready_b), .cfg_so(so_b), .cfg_commit(commit4),
    .cfg_done(done_b), .cfg_err(err_b), .cfg_state_o(state_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference routing: returns {down, right}
  function automatic logic [5:0] route3(input logic [17:0] cfg, input logic [2:0] l, input logic [2:0] u);
    logic [5:0] r;
    int s;
    r = '0;
    for (int f = 0; f < 6; f++) begin
      s = int'(cfg[f*3 +: 3]);
      if (s >= 1 && s <= 3)      r[f] = l[s-1];
      else if (s >= 4 && s <= 6) r[f] = u[s-4];
    end
    return r;
  endfunction

  function automatic logic [7:0] route4(input logic [31:0] cfg, input logic [3:0] l, input logic [3:0] u);
    logic [7:0] r;
    int s;
    r = '0;
    for (int f = 0; f < 8; f++) begin
      s = int'(cfg[f*4 +: 4]);
      if (s >= 1 && s <= 4)      r[f] = l[s-1];
      else if (s >= 5 && s <= 8) r[f] = u[s-5];
    end
    return r;
  endfunction

  function automatic logic [17:0] pack3(input int r0, input int r1, input int r2,
                                        input int d0, input int d1, input int d2);
    return {3'(d2), 3'(d1), 3'(d0), 3'(r2), 3'(r1), 3'(r0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start3_pulse();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
  endtask

  // Shift bits lo..hi of v, checking the handshake and serial out each beat
  task automatic beats3(input logic [17:0] v, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      valid3 = 1'b1;
      bit3   = v[k];
      @(negedge clk);
      check("ready3", ready3, 1'b1);
      check("so3", so3, sh3[0]);
      tick();
      sh3    = {v[k], sh3[17:1]};
      valid3 = 1'b0;
    end
  endtask

  task automatic commit3_pulse();
    commit3 = 1'b1;
    tick();
    commit3 = 1'b0;
    @(negedge clk);
    check("done3_pulse", done3, 1'b1);
    tick();
    @(negedge clk);
    check("done3_clear", done3, 1'b0);
    tick();
  endtask

  task automatic full_load3(input logic [17:0] v);
    start3_pulse();
    beats3(v, 0, 17);
    check("armed3", state3, CFG_ARMED);
    commit3_pulse();
    cur3 = v;
  endtask

  task automatic route_check3(input string tag, input logic [2:0] l, input logic [2:0] u);
    logic [15:0] e;
    left3 = l;
    up3   = u;
    exp_q.push_back({10'b0, route3(cur3, l, u)});
    @(negedge clk);
    e = exp_q.pop_front();
    check(tag, {10'b0, down3, right3}, e);
    tick();
  endtask

  task automatic beats4(input logic [31:0] v, input logic [31:0] prev);
    for (int k = 0; k < 32; k++) begin
      valid4 = 1'b1;
      bit4   = v[k];
      @(negedge clk);
      check("so_chain", so_a, prev[k]);
      tick();
      valid4 = 1'b0;
    end
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0] v_id, v_fan, v_rev, v_junk, v_bad;
    logic [3:0]  l4, u4;
    logic [15:0] e;

    rst = 1'b1;
    left3 = '0; up3 = '0; start3 = 0; valid3 = 0; bit3 = 0; commit3 = 0;
    left4 = '0; up4 = '0; start4 = 0; valid4 = 0; bit4 = 0; commit4 = 0;
    sh3 = '0; cur3 = '0;

    v_id   = pack3(1, 2, 3, 4, 5, 6);
    v_fan  = pack3(1, 1, 1, 4, 0, 0);
    v_rev  = pack3(3, 2, 1, 6, 5, 4);
    v_junk = pack3(6, 6, 6, 6, 6, 6);
    v_bad  = pack3(7, 2, 3, 4, 5, 6);

    // Reset state with live inputs
    repeat (2) @(posedge clk);
    #1;
    left3 = 3'b111; up3 = 3'b111;
    #1;
    check("rst_right", right3, 3'b000);
    check("rst_down", down3, 3'b000);
    check("rst_ready", ready3, 1'b0);
    check("rst_err", err3, 1'b0);
    check("rst_done", done3, 1'b0);
    check("rst_so", so3, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("idle_state", state3, CFG_IDLE);

    // Full identity load
    full_load3(v_id);
    route_check3("ident", 3'b101, 3'b010);
    check("ident_right", right3, 3'b101);
    check("ident_down", down3, 3'b010);
    for (int n = 0; n < 6; n++)
      route_check3("ident_rand", 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));

    // Fan-out and off, with a 5-cycle stall mid-load
    start3_pulse();
    beats3(v_fan, 0, 8);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("stall_so", so3, 1'b0);
      check("stall_state", state3, CFG_LOAD);
      tick();
    end
    beats3(v_fan, 9, 16);
    check("stall_not_armed", state3, CFG_LOAD);
    beats3(v_fan, 17, 17);
    check("stall_armed", state3, CFG_ARMED);
    commit3_pulse();
    cur3 = v_fan;
    route_check3("fanout", 3'b001, 3'b001);
    check("fan_right", right3, 3'b111);
    check("fan_down", down3, 3'b001);
    route_check3("fanout_b", 3'b110, 3'b111);

    // Restart after 10 bits; early commit ignored
    start3_pulse();
    beats3(v_junk, 0, 9);
    start3_pulse();
    beats3(v_rev, 0, 4);
    commit3 = 1'b1;
    tick();
    commit3 = 1'b0;
    check("early_commit_state", state3, CFG_LOAD);
    @(negedge clk);
    check("early_commit_done", done3, 1'b0);
    tick();
    route_check3("early_commit_route", 3'b001, 3'b001);
    beats3(v_rev, 5, 16);
    check("restart_not_armed", state3, CFG_LOAD);
    beats3(v_rev, 17, 17);
    check("restart_armed", state3, CFG_ARMED);
    commit3_pulse();
    cur3 = v_rev;
    route_check3("rev", 3'b100, 3'b011);
    route_check3("rev_b", 3'b011, 3'b110);

    // Invalid select code
    full_load3(v_bad);
    check("bad_err", err3, 1'b1);
    route_check3("bad_route", 3'b111, 3'b000);
    check("bad_right0", right3, 3'b110);
    full_load3(v_id);
    check("fixed_err", err3, 1'b0);
    route_check3("fixed_route", 3'b111, 3'b101);

    // Reset in the middle of a load
    start3_pulse();
    beats3(v_rev, 0, 4);
    left3 = 3'b111; up3 = 3'b111;
    rst = 1'b1;
    #1;
    check("midrst_right", right3, 3'b000);
    check("midrst_down", down3, 3'b000);
    check("midrst_ready", ready3, 1'b0);
    check("midrst_err", err3, 1'b0);
    check("midrst_state", state3, CFG_IDLE);
    sh3 = '0; cur3 = '0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    route_check3("post_rst_route", 3'b111, 3'b111);
    commit3 = 1'b1;
    tick();
    commit3 = 1'b0;
    check("idle_commit_state", state3, CFG_IDLE);
    @(negedge clk);
    check("idle_commit_done", done3, 1'b0);
    tick();
    full_load3(v_id);
    route_check3("reload", 3'b010, 3'b101);

    // W=4 chained tiles: stream carries tile B config first, then tile A
    for (int f = 0; f < 4; f++) begin
      cfg_a[f*4 +: 4]     = 4'(f + 1);
      cfg_a[(f+4)*4 +: 4] = 4'(f + 5);
      cfg_b[f*4 +: 4]     = 4'(f + 5);
      cfg_b[(f+4)*4 +: 4] = 4'(f + 1);
    end
    start4 = 1'b1; tick(); start4 = 1'b0;
    beats4(cfg_b, 32'h0);
    check("chain_a_armed1", state_a, CFG_ARMED);
    check("chain_b_armed1", state_b, CFG_ARMED);
    start4 = 1'b1; tick(); start4 = 1'b0;
    check("chain_a_reload", state_a, CFG_LOAD);
    beats4(cfg_a, cfg_b);
    check("chain_a_armed2", state_a, CFG_ARMED);
    check("chain_b_armed2", state_b, CFG_ARMED);
    commit4 = 1'b1; tick(); commit4 = 1'b0;
    @(negedge clk);
    check("chain_done_a", done_a, 1'b1);
    check("chain_done_b", done_b, 1'b1);
    tick();
    check("chain_err", {err_a, err_b}, 2'b00);

    // Registered outputs follow inputs exactly one cycle later
    exp_q.delete();
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      #1;
      l4 = 4'($urandom_range(0, 15));
      u4 = 4'($urandom_range(0, 15));
      left4 = l4; up4 = u4;
      exp_q.push_back({route4(cfg_b, l4, u4), route4(cfg_a, l4, u4)});
      @(negedge clk);
      if (exp_q.size() > 1) begin
        e = exp_q.pop_front();
        check("reg_route", {db, rb, da, ra}, e);
      end
    end
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("reg_route_last", {db, rb, da, ra}, e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
